// File: rtl/hamming_stream_encoder_if.sv
// Stream bus for the SECDED encoder: an input word channel and a codeword output channel.
interface hamming_stream_encoder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [1:0]            in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_mode;
  logic                  out_err;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_err
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_err
  );
endinterface

// File: rtl/hamming_stream_encoder.sv
// Streaming extended-Hamming (SECDED) encoder: S1 computes Hamming parity, S2 adds overall
// parity and packs the codeword; both stages are backpressured, with saturating statistics.
module hamming_stream_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  hamming_stream_encoder_if.slave bus,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    word_cnt,
  output logic [CNT_WIDTH-1:0]    err_cnt
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic int data_bits(input logic [1:0] mode);
    return (8 << mode) - 4 - int'(mode);
  endfunction

  // Each set data bit flips exactly the parity bits named by its Hamming position,
  // so the parity vector is the XOR of the positions of all set data bits.
  function automatic logic [5:0] hamming_par(input logic [63:0] d);
    logic [5:0] par;
    int         k;
    par = '0;
    k   = 0;
    for (int pos = 1; pos < 64; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (((d >> k) & 64'd1) != 64'd0) par = par ^ 6'(pos);
        k++;
      end
    end
    return par;
  endfunction

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [5:0]            s1_par_q,   s1_par_d;
  logic [1:0]            s1_mode_q,  s1_mode_d;
  logic                  s1_err_q,   s1_err_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]            out_mode_q,  out_mode_d;
  logic                  out_err_q,   out_err_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q,  word_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q,   err_cnt_d;

  logic                  s2_free, in_ready, in_fire, s1_move, out_fire;
  logic                  in_legal;
  int                    in_k;
  logic [DATA_WIDTH-1:0] din_m;
  logic [63:0]           din_ext;
  logic [2:0]            p_len;
  logic                  q_bit;
  logic [DATA_WIDTH-1:0] code;

  // Stage 1 datapath: mask to K bits (all zero for an illegal mode) and form Hamming parity.
  always_comb begin
    in_k     = data_bits(bus.in_mode);
    in_legal = (8 << bus.in_mode) <= DATA_WIDTH;
    din_m    = bus.in_data & ((DATA_WIDTH'(1) << in_k) - DATA_WIDTH'(1));
    if (!in_legal) din_m = '0;
    din_ext = '0;
    din_ext[DATA_WIDTH-1:0] = din_m;
  end

  // Stage 2 datapath: overall parity over d and p, then {d, q, p} packed LSB first.
  always_comb begin
    p_len = 3'd3 + {1'b0, s1_mode_q};
    q_bit = (^s1_data_q) ^ (^s1_par_q);
    code  = (s1_data_q << (p_len + 3'd1)) | (DATA_WIDTH'(q_bit) << p_len) | DATA_WIDTH'(s1_par_q);
    if (s1_err_q) code = '0;
  end

  always_comb begin
    s2_free  = !out_valid_q || bus.out_ready;
    in_ready = !s1_valid_q || s2_free;
    in_fire  = bus.in_valid && in_ready;
    s1_move  = s1_valid_q && s2_free;
    out_fire = out_valid_q && bus.out_ready;

    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_par_d    = s1_par_q;
    s1_mode_d   = s1_mode_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    out_err_d   = out_err_q;
    word_cnt_d  = word_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = din_m;
      s1_par_d   = hamming_par(din_ext);
      s1_mode_d  = bus.in_mode;
      s1_err_d   = !in_legal;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    if (s1_move) begin
      out_valid_d = 1'b1;
      out_data_d  = code;
      out_mode_d  = s1_mode_q;
      out_err_d   = s1_err_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (cnt_clr) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (out_fire) begin
      if (word_cnt_q != CNT_MAX) word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
      if (out_err_q && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_par_q    <= '0;
      s1_mode_q   <= '0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= '0;
      out_err_q   <= 1'b0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_par_q    <= s1_par_d;
      s1_mode_q   <= s1_mode_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      out_err_q   <= out_err_d;
      word_cnt_q  <= word_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.out_err   = out_err_q;
  assign word_cnt      = word_cnt_q;
  assign err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Bench for hamming_stream_encoder: a 32-bit (3-bit counters) and a 64-bit instance share one
// stimulus stream and are checked every cycle against a queue-based behavioural model.
module tb_hamming_stream_encoder;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready, cnt_clr;
  logic [63:0] in_data;
  logic [1:0]  in_mode;
  logic [2:0]  wc32_o, ec32_o;
  logic [15:0] wc64_o, ec64_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hamming_stream_encoder_if #(.DATA_WIDTH(32)) if32 ();
  hamming_stream_encoder_if #(.DATA_WIDTH(64)) if64 ();

  assign if32.in_valid  = in_valid;
  assign if32.in_data   = in_data[31:0];
  assign if32.in_mode   = in_mode;
  assign if32.out_ready = out_ready;
  assign if64.in_valid  = in_valid;
  assign if64.in_data   = in_data;
  assign if64.in_mode   = in_mode;
  assign if64.out_ready = out_ready;

  hamming_stream_encoder #(.DATA_WIDTH(32), .CNT_WIDTH(3)) dut32 (
    .clk(clk), .reset(reset), .bus(if32), .cnt_clr(cnt_clr), .word_cnt(wc32_o), .err_cnt(ec32_o)
  );
  hamming_stream_encoder #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut64 (
    .clk(clk), .reset(reset), .bus(if64), .cnt_clr(cnt_clr), .word_cnt(wc64_o), .err_cnt(ec64_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Codeword built straight from the code definition: place d at non-power-of-two positions,
  // derive each parity bit from the positions it covers, then pack {d, q, p}.
  function automatic logic [63:0] enc(input logic [63:0] d, input logic [1:0] m, input int dw);
    int w, p, j, b, par, qp;
    logic [63:0] r;
    w = 8 << m;
    p = 3 + int'(m);
    r = '0;
    if (w > dw) return r;
    j = 0; par = 0; qp = 0;
    for (int pos = 1; pos < w; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        b = int'((d >> j) & 64'd1);
        j++;
        qp ^= b;
        r |= 64'(b) << (p + j);
        if (b != 0)
          for (int i = 0; i < p; i++)
            if (((pos >> i) & 1) != 0) par ^= (1 << i);
      end
    end
    for (int i = 0; i < p; i++)
      if (((par >> i) & 1) != 0) begin
        qp ^= 1;
        r |= 64'd1 << i;
      end
    r |= 64'(qp) << p;
    return r;
  endfunction

  typedef struct {
    logic [63:0] d;
    logic [1:0]  m;
    int          t;
  } word_t;

  word_t       mq[$];
  int          tcnt = 0;
  int          wc32 = 0, ec32 = 0, wc64 = 0, ec64 = 0;
  logic        exp_ov, exp_ir, e32, stall_prev = 1'b0;
  logic [63:0] prev32, prev64;

  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      wc32 = 0; ec32 = 0; wc64 = 0; ec64 = 0;
      stall_prev = 1'b0;
      chk("rst_valid32", 64'(if32.out_valid), 64'd0);
      chk("rst_valid64", 64'(if64.out_valid), 64'd0);
      chk("rst_data32", 64'(if32.out_data), 64'd0);
      chk("rst_mode_err32", 64'({if32.out_mode, if32.out_err}), 64'd0);
      chk("rst_cnt32", 64'({wc32_o, ec32_o}), 64'd0);
      chk("rst_cnt64", 64'({wc64_o, ec64_o}), 64'd0);
    end else begin
      exp_ov = (mq.size() > 0) && (tcnt - mq[0].t >= 2);
      exp_ir = (mq.size() < 2) || out_ready;
      chk("in_ready32", 64'(if32.in_ready), 64'(exp_ir));
      chk("in_ready64", 64'(if64.in_ready), 64'(exp_ir));
      chk("out_valid32", 64'(if32.out_valid), 64'(exp_ov));
      chk("out_valid64", 64'(if64.out_valid), 64'(exp_ov));
      e32 = 1'b0;
      if (exp_ov) begin
        e32 = (8 << mq[0].m) > 32;
        chk("data32", 64'(if32.out_data), enc(mq[0].d, mq[0].m, 32));
        chk("data64", if64.out_data, enc(mq[0].d, mq[0].m, 64));
        chk("mode32", 64'(if32.out_mode), 64'(mq[0].m));
        chk("mode64", 64'(if64.out_mode), 64'(mq[0].m));
        chk("err32", 64'(if32.out_err), 64'(e32));
        chk("err64", 64'(if64.out_err), 64'd0);
      end
      if (stall_prev) begin
        chk("stable32", 64'(if32.out_data), prev32);
        chk("stable64", if64.out_data, prev64);
      end
      chk("word_cnt32", 64'(wc32_o), 64'(wc32));
      chk("err_cnt32", 64'(ec32_o), 64'(ec32));
      chk("word_cnt64", 64'(wc64_o), 64'(wc64));
      chk("err_cnt64", 64'(ec64_o), 64'(ec64));

      stall_prev = exp_ov && !out_ready;
      prev32 = 64'(if32.out_data);
      prev64 = if64.out_data;
      if (exp_ov && out_ready) begin
        void'(mq.pop_front());
        if (wc32 < 7) wc32++;
        if (e32 && ec32 < 7) ec32++;
        if (wc64 < 65535) wc64++;
      end
      if (cnt_clr) begin
        wc32 = 0; ec32 = 0; wc64 = 0; ec64 = 0;
      end
      if (in_valid && exp_ir) mq.push_back('{d: in_data, m: in_mode, t: tcnt});
      tcnt++;
    end
  end

  task automatic send(input logic [63:0] d, input logic [1:0] m, input logic clr_at_out,
                      input logic [63:0] exp32, input logic [63:0] exp64, input logic experr32,
                      input string nm);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_mode = m; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_early"}, 64'(if32.out_valid), 64'd0);
    @(posedge clk); #1;
    cnt_clr = clr_at_out;
    @(negedge clk);
    chk({nm, "_valid"}, 64'(if32.out_valid), 64'd1);
    chk({nm, "_data32"}, 64'(if32.out_data), exp32);
    chk({nm, "_data64"}, if64.out_data, exp64);
    chk({nm, "_err32"}, 64'(if32.out_err), 64'(experr32));
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    chk("model_m0", enc(64'hB, 2'd0, 32), 64'hB1);
    chk("model_m0b", enc(64'h5, 2'd0, 32), 64'h55);
    chk("model_m1", enc(64'h1, 2'd1, 32), 64'h33);
    chk("model_m2", enc(64'h1, 2'd2, 32), 64'h63);
    chk("model_m3_64", enc(64'h1, 2'd3, 64), 64'hC3);
    chk("model_m3_32", enc(64'h1, 2'd3, 32), 64'h0);

    send(64'hB, 2'd0, 1'b0, 64'hB1, 64'hB1, 1'b0, "m0");
    send(64'h1, 2'd1, 1'b0, 64'h33, 64'h33, 1'b0, "m1");
    send(64'h1, 2'd2, 1'b0, 64'h63, 64'h63, 1'b0, "m2");
    send(64'h1, 2'd3, 1'b0, 64'h0, 64'hC3, 1'b1, "m3");
    @(negedge clk);
    chk("dir_word32", 64'(wc32_o), 64'd4);
    chk("dir_err32", 64'(ec32_o), 64'd1);
    chk("dir_err64", 64'(ec64_o), 64'd0);

    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = {$urandom(), $urandom()};
      in_mode  = 2'($urandom_range(0, 2));
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_word32", 64'(wc32_o), 64'd7);
    chk("sat_word64", 64'(wc64_o), 64'd9);

    send(64'h1, 2'd3, 1'b1, 64'h0, 64'hC3, 1'b1, "clr_hs");
    @(negedge clk);
    chk("clr_word32", 64'(wc32_o), 64'd0);
    chk("clr_err32", 64'(ec32_o), 64'd0);
    chk("clr_word64", 64'(wc64_o), 64'd0);

    repeat (400) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom(), $urandom()};
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 1) != 0);
      cnt_clr   = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (4) @(posedge clk);

    #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = {$urandom(), $urandom()}; in_mode = 2'd1;
    @(posedge clk); #1;
    in_data = {$urandom(), $urandom()}; in_mode = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("held_in_ready", 64'(if32.in_ready), 64'd0);
    chk("held_out_valid", 64'(if32.out_valid), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_valid32", 64'(if32.out_valid), 64'd0);
    chk("async_valid64", 64'(if64.out_valid), 64'd0);
    chk("async_data64", if64.out_data, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; out_ready = 1'b1;
    send(64'h5, 2'd0, 1'b0, 64'h55, 64'h55, 1'b0, "post_rst");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hamming_stream_encoder.md
# hamming_stream_encoder

- Streaming, parametrised extended-Hamming (SECDED) encoder.
- Accepts one data word per cycle with a per-word codeword-size mode over a valid/ready handshake.
- Emits the packed codeword through a 2-stage backpressured pipeline and keeps saturating word and error counters.
- Sits between the register/APB front end and the channel/noise path, as the generalised successor of the fixed 8/16/32 encoder; it adds a 64-bit mode, flow control and statistics.

## Interface

Parameters:
- DATA_WIDTH, 32 — maximum codeword width; legal values 8, 16, 32, 64.
- CNT_WIDTH, 16 — width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  encoder can accept a word this cycle.
- in_data  in  DATA_WIDTH  data bits, LSB-aligned; bits at or above K are ignored.
- in_mode  in  2  codeword width: 00=8 (K=4, P=3), 01=16 (K=11, P=4), 10=32 (K=26, P=5), 11=64 (K=57, P=6).
- out_valid  out  1  codeword valid.
- out_ready  in  1  downstream accepts the codeword.
- out_data  out  DATA_WIDTH  packed codeword.
- out_mode  out  2  mode that travelled with the word.
- out_err  out  1  the word's mode was illegal for DATA_WIDTH.
- cnt_clr  in  1  synchronous clear of both counters.
- word_cnt  out  CNT_WIDTH  accepted output words, saturating.
- err_cnt  out  CNT_WIDTH  accepted output words with out_err=1, saturating.

## Operation

- Mode legality: a mode is legal iff its codeword width ≤ DATA_WIDTH.
- Data placement: data bit d[k] occupies the k-th non-power-of-two Hamming position (1-based), in order: d0→3, d1→5, d2→6, d3→7, d4→9, and so on.
- Hamming parity: p[i], i=0..P-1, is the XOR of every data bit whose position has bit i set.
- Overall parity: q is the XOR of d[K-1:0] and p[P-1:0].
- Packing (W = codeword width): out_data[P-1:0]=p, out_data[P]=q, out_data[W-1:P+1]=d[K-1:0], out_data[DATA_WIDTH-1:W]=0.
- Illegal mode: out_data=0 and out_err=1. The word still flows through the pipeline and is counted.
- Stage 1 (S1):
  - Captures in_data and in_mode on the input handshake.
  - Computes legality and p in the same cycle.
  - Registers {d, p, mode, err}.
- Stage 2 (S2):
  - Computes q and packs the codeword.
  - Registers out_data, out_mode and out_err.
- Flow control:
  - s2_free = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_free.
  - S1 transfers to S2 when s1_valid && s2_free.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_mode and out_err hold stable. No word is dropped or duplicated.
- Counters:
  - On each output handshake (out_valid && out_ready), word_cnt increments; err_cnt increments if out_err=1.
  - Both counters saturate at all-ones.
  - cnt_clr=1 sets both to 0 next cycle; clear wins over a same-cycle increment.

## Timing

- Reset: out_valid=0, out_data=0, out_mode=0, out_err=0, word_cnt=0, err_cnt=0, internal valids=0.
- in_ready is 1 from the first cycle after reset deassertion.
- Latency: a word accepted at edge N is presented with out_valid=1 after edge N+2.
- Throughput: 1 word/cycle with out_ready held high.
- Backpressure: with out_ready=0, at most 2 words are held. in_ready drops combinationally when both stages are full.
- Release: in_ready returns in the same cycle that out_ready rises.
- Reset mid-operation: all in-flight words are discarded. Outputs return to their reset values asynchronously.
- in_mode is sampled per word. Mixed modes back-to-back are legal and each word is encoded with its own mode.

## Test plan

- Mode 00, in_data=4'hB → out_data=8'hB1, out_err=0, out_valid exactly 2 cycles after accept.
- Mode 01, in_data=11'h001 → out_data=16'h0033; mode 10, in_data=26'h1 → out_data=32'h00000063.
- DATA_WIDTH=64, mode 11, in_data=57'h1 → out_data=64'hC3. DATA_WIDTH=32, mode 11, any data → out_data=0, out_err=1, err_cnt=1.
- Stream 8 words with mixed modes while out_ready toggles randomly → every codeword matches the software model, in order, no loss or duplication; in_ready=0 only when 2 words are held; output stable while stalled.
- Preload word_cnt to all-ones-1, complete 3 handshakes → word_cnt saturates at all-ones. Assert cnt_clr on the same cycle as a handshake → both counters read 0 next cycle.
- Assert reset with 2 words in flight → out_valid=0 immediately. After release, the first new word emerges after 2 cycles with correct data.
